point_sweep_controller: RTL and testbench



---
 rtl/point_sweep_controller.sv | 140 ++++++++++++++
 tb/tb_point_sweep_controller.sv | 311 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/point_sweep_controller.sv
// rtl/point_sweep_controller.sv - mass-point state store that sweeps each point through update_point
module point_sweep_controller #(
  parameter int POSITION_SIZE = 8,
  parameter int VELOCITY_SIZE = 8,
  parameter int NUM_POINTS    = 4,
  parameter int IDX_SIZE      = 4,
  parameter int TIMEOUT       = 255
) (
  input  logic                     clk_in,
  input  logic                     rst_in,
  input  logic                     step_in,
  input  logic [IDX_SIZE-1:0]      num_points_in,
  input  logic                     load_valid_in,
  input  logic [IDX_SIZE-1:0]      load_idx_in,
  input  logic [POSITION_SIZE-1:0] load_pos_x_in,
  input  logic [POSITION_SIZE-1:0] load_pos_y_in,
  input  logic [VELOCITY_SIZE-1:0] load_vel_x_in,
  input  logic [VELOCITY_SIZE-1:0] load_vel_y_in,
  input  logic [IDX_SIZE-1:0]      rd_idx_in,
  output logic [POSITION_SIZE-1:0] rd_pos_x_out,
  output logic [POSITION_SIZE-1:0] rd_pos_y_out,
  output logic [VELOCITY_SIZE-1:0] rd_vel_x_out,
  output logic [VELOCITY_SIZE-1:0] rd_vel_y_out,
  output logic                     upd_begin_out,
  output logic [POSITION_SIZE-1:0] upd_pos_x_out,
  output logic [POSITION_SIZE-1:0] upd_pos_y_out,
  output logic [VELOCITY_SIZE-1:0] upd_vel_x_out,
  output logic [VELOCITY_SIZE-1:0] upd_vel_y_out,
  input  logic                     upd_result_in,
  input  logic [POSITION_SIZE-1:0] upd_pos_x_in,
  input  logic [POSITION_SIZE-1:0] upd_pos_y_in,
  input  logic [VELOCITY_SIZE-1:0] upd_vel_x_in,
  input  logic [VELOCITY_SIZE-1:0] upd_vel_y_in,
  output logic                     busy_out,
  output logic                     done_out,
  output logic                     timeout_out
);

  localparam int AW = (NUM_POINTS > 1) ? $clog2(NUM_POINTS) : 1;
  localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
  localparam int W  = 2 * POSITION_SIZE + 2 * VELOCITY_SIZE;
  localparam logic [IDX_SIZE:0] NP = (IDX_SIZE + 1)'(NUM_POINTS);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

  state_t              state;
  logic [W-1:0]        mem [NUM_POINTS];
  logic [IDX_SIZE-1:0] idx;
  logic [IDX_SIZE:0]   n;
  logic [CW-1:0]       wait_cnt;

  logic [IDX_SIZE:0]   n_clamped;
  logic [IDX_SIZE-1:0] idx_nxt;
  logic                last_pt;
  logic                load_ok;
  logic [W-1:0]        rd_word;
  logic [W-1:0]        nxt_word;
  logic [W-1:0]        wb_word;
  logic [W-1:0]        ld_word;

  // n is one bit wider than an index so NUM_POINTS == 2**IDX_SIZE still fits
  always_comb begin
    n_clamped = ({1'b0, num_points_in} > NP) ? NP : {1'b0, num_points_in};
    idx_nxt   = idx + 1'b1;
    last_pt   = ({1'b0, idx} == n - 1'b1);
    load_ok   = load_valid_in && ({1'b0, load_idx_in} < NP);
    rd_word   = ({1'b0, rd_idx_in} < NP) ? mem[rd_idx_in[AW-1:0]] : '0;
    nxt_word  = mem[idx_nxt[AW-1:0]];
    wb_word   = {upd_pos_x_in, upd_pos_y_in, upd_vel_x_in, upd_vel_y_in};
    ld_word   = {load_pos_x_in, load_pos_y_in, load_vel_x_in, load_vel_y_in};
  end

  always_ff @(posedge clk_in) begin
    if (!rst_in) begin
      state         <= IDLE;
      idx           <= '0;
      n             <= '0;
      wait_cnt      <= '0;
      for (int i = 0; i < NUM_POINTS; i++) mem[i] <= '0;
      {rd_pos_x_out, rd_pos_y_out, rd_vel_x_out, rd_vel_y_out}     <= '0;
      {upd_pos_x_out, upd_pos_y_out, upd_vel_x_out, upd_vel_y_out} <= '0;
      upd_begin_out <= 1'b0;
      busy_out      <= 1'b0;
      done_out      <= 1'b0;
      timeout_out   <= 1'b0;
    end else begin
      upd_begin_out <= 1'b0;
      done_out      <= 1'b0;
      {rd_pos_x_out, rd_pos_y_out, rd_vel_x_out, rd_vel_y_out} <= rd_word;
      case (state)
        IDLE: begin
          if (step_in) begin
            n           <= n_clamped;
            idx         <= '0;
            timeout_out <= 1'b0;
            busy_out    <= 1'b1;
            if (n_clamped == '0) begin
              state    <= DONE;
              done_out <= 1'b1;
            end else begin
              state         <= ISSUE;
              upd_begin_out <= 1'b1;
              {upd_pos_x_out, upd_pos_y_out, upd_vel_x_out, upd_vel_y_out} <= mem[0];
            end
          end else if (load_ok) begin
            mem[load_idx_in[AW-1:0]] <= ld_word;
          end
        end
        ISSUE: begin
          state    <= WAIT;
          wait_cnt <= '0;
        end
        WAIT: begin
          // a result and a timeout both retire the point; only a result writes back
          if (upd_result_in || wait_cnt == CW'(TIMEOUT - 1)) begin
            if (upd_result_in) mem[idx[AW-1:0]] <= wb_word;
            else               timeout_out      <= 1'b1;
            if (last_pt) begin
              state    <= DONE;
              done_out <= 1'b1;
            end else begin
              idx           <= idx_nxt;
              state         <= ISSUE;
              upd_begin_out <= 1'b1;
              {upd_pos_x_out, upd_pos_y_out, upd_vel_x_out, upd_vel_y_out} <= nxt_word;
            end
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
        end
        DONE: begin
          state    <= IDLE;
          busy_out <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_point_sweep_controller.sv
// tb/tb_point_sweep_controller.sv - randomized scoreboard bench for point_sweep_controller
module tb_point_sweep_controller;

  localparam int P  = 8;
  localparam int V  = 8;
  localparam int NP = 4;
  localparam int IW = 4;
  localparam int TO = 8;

  typedef struct packed {
    logic [P-1:0] px;
    logic [P-1:0] py;
    logic [V-1:0] vx;
    logic [V-1:0] vy;
  } pt_t;

  typedef struct {
    int  kind;
    pt_t v;
    int  gmin;
    int  gmax;
    bit  tmo;
  } ev_t;

  logic          clk_in = 1'b0;
  logic          rst_in = 1'b0;
  logic          step_in = 1'b0;
  logic [IW-1:0] num_points_in = '0;
  logic          load_valid_in = 1'b0;
  logic [IW-1:0] load_idx_in = '0;
  logic [P-1:0]  load_pos_x_in = '0, load_pos_y_in = '0;
  logic [V-1:0]  load_vel_x_in = '0, load_vel_y_in = '0;
  logic [IW-1:0] rd_idx_in = '0;
  logic [P-1:0]  rd_pos_x_out, rd_pos_y_out;
  logic [V-1:0]  rd_vel_x_out, rd_vel_y_out;
  logic          upd_begin_out;
  logic [P-1:0]  upd_pos_x_out, upd_pos_y_out;
  logic [V-1:0]  upd_vel_x_out, upd_vel_y_out;
  logic          upd_result_in = 1'b0;
  logic [P-1:0]  upd_pos_x_in = '0, upd_pos_y_in = '0;
  logic [V-1:0]  upd_vel_x_in = '0, upd_vel_y_in = '0;
  logic          busy_out, done_out, timeout_out;

  point_sweep_controller #(
    .POSITION_SIZE(P), .VELOCITY_SIZE(V), .NUM_POINTS(NP), .IDX_SIZE(IW), .TIMEOUT(TO)
  ) dut (
    .clk_in(clk_in), .rst_in(rst_in), .step_in(step_in), .num_points_in(num_points_in),
    .load_valid_in(load_valid_in), .load_idx_in(load_idx_in),
    .load_pos_x_in(load_pos_x_in), .load_pos_y_in(load_pos_y_in),
    .load_vel_x_in(load_vel_x_in), .load_vel_y_in(load_vel_y_in),
    .rd_idx_in(rd_idx_in),
    .rd_pos_x_out(rd_pos_x_out), .rd_pos_y_out(rd_pos_y_out),
    .rd_vel_x_out(rd_vel_x_out), .rd_vel_y_out(rd_vel_y_out),
    .upd_begin_out(upd_begin_out),
    .upd_pos_x_out(upd_pos_x_out), .upd_pos_y_out(upd_pos_y_out),
    .upd_vel_x_out(upd_vel_x_out), .upd_vel_y_out(upd_vel_y_out),
    .upd_result_in(upd_result_in),
    .upd_pos_x_in(upd_pos_x_in), .upd_pos_y_in(upd_pos_y_in),
    .upd_vel_x_in(upd_vel_x_in), .upd_vel_y_in(upd_vel_y_in),
    .busy_out(busy_out), .done_out(done_out), .timeout_out(timeout_out)
  );

  always #5 clk_in = ~clk_in;

  int cyc = 0;
  always @(posedge clk_in) cyc <= cyc + 1;

  int   n_tests = 0;
  int   n_fail  = 0;
  pt_t  model [NP];
  ev_t  exp_q [$];
  int   last_cyc = 0;
  int   rsp_delay [NP];
  bit   rsp_silent [NP];
  int   rsp_k = 0;
  int   rsp_cnt = 0;
  pt_t  rsp_v;
  pt_t  held = '0;
  pt_t  mon_cur;
  ev_t  mon_ev;
  bit   idle_next = 1'b0;

  function automatic void chk(string name, longint act, longint exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endfunction

  function automatic void chk_range(string name, int act, int lo, int hi);
    n_tests++;
    if (act < lo || act > hi) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d..%0d (cycle %0d)", name, act, lo, hi, cyc);
    end
  endfunction

  // what the external update_point does: integrate position by velocity
  function automatic pt_t step_point(pt_t p);
    pt_t r;
    r    = p;
    r.px = p.px + p.vx;
    r.py = p.py + p.vy;
    return r;
  endfunction

  // update_point stand-in: replies delay+1 negedges after begin, or stays silent
  initial forever begin
    @(negedge clk_in);
    upd_result_in = 1'b0;
    if (rsp_cnt > 0) begin
      rsp_cnt--;
      if (rsp_cnt == 0) begin
        upd_result_in = 1'b1;
        {upd_pos_x_in, upd_pos_y_in, upd_vel_x_in, upd_vel_y_in} = step_point(rsp_v);
      end
    end
    if (upd_begin_out) begin
      if (rsp_k < NP && !rsp_silent[rsp_k]) begin
        rsp_v   = {upd_pos_x_out, upd_pos_y_out, upd_vel_x_out, upd_vel_y_out};
        rsp_cnt = rsp_delay[rsp_k] + 1;
      end
      rsp_k++;
    end
  end

  // monitor: pops one expected event per begin/done pulse
  initial forever begin
    @(negedge clk_in);
    mon_cur = {upd_pos_x_out, upd_pos_y_out, upd_vel_x_out, upd_vel_y_out};
    if (idle_next) begin
      idle_next = 1'b0;
      chk("busy_after_done", busy_out, 0);
    end
    if (upd_begin_out || done_out) begin
      if (exp_q.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL unexpected_event: begin=%0b done=%0b expected none (cycle %0d)",
                 upd_begin_out, done_out, cyc);
      end else begin
        mon_ev = exp_q.pop_front();
        chk("event_kind", upd_begin_out ? 0 : 1, mon_ev.kind);
        chk_range("event_gap", cyc - last_cyc, mon_ev.gmin, mon_ev.gmax);
        chk("busy_in_sweep", busy_out, 1);
        if (mon_ev.kind == 0) begin
          chk("begin_data", mon_cur, mon_ev.v);
        end else begin
          chk("done_timeout_flag", timeout_out, mon_ev.tmo);
          idle_next = 1'b1;
        end
        last_cyc = cyc;
      end
    end else if (busy_out) begin
      chk("upd_held", mon_cur, held);
    end
    if (upd_begin_out) held = mon_cur;
  end

  task automatic do_reset();
    @(negedge clk_in);
    rst_in = 1'b0;
    @(negedge clk_in);
    rst_in = 1'b1;
    for (int i = 0; i < NP; i++) model[i] = '0;
    exp_q.delete();
    idle_next = 1'b0;
  endtask

  task automatic load(int idx, pt_t v);
    @(negedge clk_in);
    load_valid_in = 1'b1;
    load_idx_in   = IW'(idx);
    {load_pos_x_in, load_pos_y_in, load_vel_x_in, load_vel_y_in} = v;
    @(negedge clk_in);
    load_valid_in = 1'b0;
    if (idx < NP) model[idx] = v;
  endtask

  task automatic read_all();
    pt_t exp_v;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk_in);
      rd_idx_in = IW'(i);
      @(negedge clk_in);
      exp_v = (i < NP) ? model[i] : '0;
      chk($sformatf("read_%0d", i), {rd_pos_x_out, rd_pos_y_out, rd_vel_x_out, rd_vel_y_out}, exp_v);
    end
  endtask

  // one sweep; delay < 0 picks a random reply delay per point
  task automatic sweep(int n_req, bit [NP-1:0] silent, bit disturb, int delay);
    int n_eff, gl, gh, d;
    bit any_to;
    n_eff  = (n_req > NP) ? NP : n_req;
    gl     = 1;
    gh     = 1;
    any_to = 1'b0;
    for (int i = 0; i < n_eff; i++) begin
      d             = (delay < 0) ? int'($urandom_range(0, 4)) : delay;
      rsp_delay[i]  = d;
      rsp_silent[i] = silent[i];
      exp_q.push_back('{0, model[i], gl, gh, 1'b0});
      if (silent[i]) begin
        gl     = TO;
        gh     = TO + 2;
        any_to = 1'b1;
      end else begin
        model[i] = step_point(model[i]);
        gl       = d + 2;
        gh       = d + 2;
      end
    end
    exp_q.push_back('{1, pt_t'(0), gl, gh, any_to});
    rsp_k = 0;
    @(negedge clk_in);
    step_in       = 1'b1;
    num_points_in = IW'(n_req);
    last_cyc      = cyc;
    @(negedge clk_in);
    step_in = 1'b0;
    if (disturb) begin
      step_in       = 1'b1;
      num_points_in = IW'($urandom_range(0, 15));
      load_valid_in = 1'b1;
      load_idx_in   = IW'($urandom_range(0, NP - 1));
      {load_pos_x_in, load_pos_y_in, load_vel_x_in, load_vel_y_in} = $urandom;
      @(negedge clk_in);
      step_in       = 1'b0;
      load_valid_in = 1'b0;
    end
    for (int c = 0; c < 300 && exp_q.size() != 0; c++) @(negedge clk_in);
    if (exp_q.size() != 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL sweep_finish: %0d events still pending after 300 cycles", exp_q.size());
      exp_q.delete();
    end
    repeat (2) @(negedge clk_in);
  endtask

  initial begin
    repeat (2) @(negedge clk_in);
    rst_in = 1'b1;
    @(negedge clk_in);
    chk("reset_begin", upd_begin_out, 0);
    chk("reset_busy", busy_out, 0);
    chk("reset_done", done_out, 0);
    chk("reset_timeout", timeout_out, 0);
    read_all();

    load(0, pt_t'({8'd10, 8'd20, 8'd1, 8'hFE}));
    sweep(1, '0, 1'b0, 3);
    read_all();

    for (int i = 0; i < NP; i++) load(i, pt_t'($urandom));
    load(5, pt_t'($urandom));
    sweep(4, '0, 1'b0, 0);
    read_all();

    for (int i = 0; i < 3; i++) load(i, pt_t'($urandom));
    sweep(3, 4'b0010, 1'b0, -1);
    read_all();
    sweep(3, '0, 1'b0, -1);

    sweep(4, '0, 1'b1, -1);
    read_all();

    // reset while waiting on point 0; the reply lands in IDLE and must be dropped
    load(0, pt_t'($urandom));
    rsp_delay[0]  = 6;
    rsp_silent[0] = 1'b0;
    exp_q.push_back('{0, model[0], 1, 1, 1'b0});
    rsp_k = 0;
    @(negedge clk_in);
    step_in       = 1'b1;
    num_points_in = IW'(1);
    last_cyc      = cyc;
    @(negedge clk_in);
    step_in = 1'b0;
    @(negedge clk_in);
    do_reset();
    repeat (10) @(negedge clk_in);
    chk("abort_busy", busy_out, 0);
    chk("abort_timeout", timeout_out, 0);
    read_all();
    sweep(0, '0, 1'b0, -1);

    for (int it = 0; it < 25; it++) begin
      bit [NP-1:0] sil;
      for (int k = 0; k < int'($urandom_range(0, 3)); k++)
        load(int'($urandom_range(0, 5)), pt_t'($urandom));
      sil = '0;
      for (int b = 0; b < NP; b++) sil[b] = ($urandom_range(0, 7) == 0);
      sweep(int'($urandom_range(0, 7)), sil, 1'($urandom_range(0, 1)), -1);
      if (it % 4 == 3) read_all();
    end
    read_all();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

endmodule
